decode_stage: RTL and testbench



---
 rtl/decode_stage_pkg.sv | 65 ++++++
 rtl/decode_logic.sv | 126 ++++++++++++
 rtl/decode_stage.sv | 112 +++++++++++
 tb/tb_decode_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// ISA constants and the decoded control bundle shared by the decode stage and its decoder.
package decode_stage_pkg;

  localparam int ISA_INST_W = 16;

  localparam logic [1:0] TYPE_REGISTER = 2'd0;
  localparam logic [1:0] TYPE_LOAD     = 2'd1;
  localparam logic [1:0] TYPE_STORE    = 2'd2;
  localparam logic [1:0] TYPE_SCOND    = 2'd3;

  localparam logic [3:0] COND_NEVER = 4'b1111;

  localparam logic [1:0] ALU_B_SEL_REG    = 2'd0;
  localparam logic [1:0] ALU_B_SEL_IMM    = 2'd1;
  localparam logic [1:0] ALU_B_SEL_IMM_HI = 2'd2;
  localparam logic [1:0] ALU_B_SEL_MEM    = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_CMP  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_MOV  = 4'd7;
  localparam logic [3:0] ALU_LSH  = 4'd8;
  localparam logic [3:0] ALU_ASH  = 4'd9;

  // Major opcodes in inst[15:12]; ALU immediate forms reuse the register-form ext codes.
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVLI = 4'b1101;
  localparam logic [3:0] OP_MOVUI = 4'b1111;

  localparam logic [3:0] MEM_LOAD  = 4'b0000;
  localparam logic [3:0] MEM_STOR  = 4'b0100;
  localparam logic [3:0] MEM_JCOND = 4'b1100;
  localparam logic [3:0] MEM_SCOND = 4'b1101;

  typedef struct packed {
    logic [7:0] inst_imm;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] reg_dst;
    logic [3:0] cond;
    logic [1:0] inst_type;
    logic       pc_disp_abs;
    logic       alu_b_imm_extend;
    logic [1:0] alu_b_sel;
    logic [3:0] alu_opcode;
    logic       update_flags;
    logic       update_regfile;
    logic       illegal;
  } decode_bundle_t;

  function automatic decode_bundle_t nop_bundle();
    decode_bundle_t b;
    b = '0;
    b.cond = COND_NEVER;
    return b;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// Pure combinational instruction-to-control-bundle decoder.
module decode_logic
  import decode_stage_pkg::*;
(
  input  logic [ISA_INST_W-1:0] inst,
  output decode_bundle_t        bundle
);

  logic [3:0] op, f_hi, f_mid, f_lo;
  logic [3:0] alu_code, alu_op;
  logic       alu_ok, alu_arith;

  assign op    = inst[15:12];
  assign f_hi  = inst[11:8];
  assign f_mid = inst[7:4];
  assign f_lo  = inst[3:0];
  assign alu_code = (op == OP_REG) ? f_mid : op;

  always_comb begin
    alu_ok    = 1'b1;
    alu_arith = 1'b0;
    alu_op    = ALU_ADD;
    case (alu_code)
      4'b0001: alu_op = ALU_AND;
      4'b0010: alu_op = ALU_OR;
      4'b0011: alu_op = ALU_XOR;
      4'b0101: begin alu_op = ALU_ADD;  alu_arith = 1'b1; end
      4'b0111: begin alu_op = ALU_ADDC; alu_arith = 1'b1; end
      4'b1001: begin alu_op = ALU_SUB;  alu_arith = 1'b1; end
      4'b1011: begin alu_op = ALU_CMP;  alu_arith = 1'b1; end
      4'b1101: alu_op = ALU_MOV;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    bundle = nop_bundle();
    case (op)
      OP_REG: begin
        // All-zero word is WAIT: a legal NOP bundle.
        if (inst[11:0] != 12'h000) begin
          if (alu_ok) begin
            bundle.reg_dst        = f_hi;
            bundle.reg_a          = f_hi;
            bundle.reg_b          = f_lo;
            bundle.alu_b_sel      = ALU_B_SEL_REG;
            bundle.alu_opcode     = alu_op;
            bundle.update_flags   = alu_arith;
            bundle.update_regfile = (alu_op != ALU_CMP);
          end else begin
            bundle.illegal = 1'b1;
          end
        end
      end
      OP_MEM: begin
        case (f_hi)
          MEM_LOAD: begin
            bundle.inst_type      = TYPE_LOAD;
            bundle.reg_dst        = f_mid;
            bundle.reg_b          = f_lo;
            bundle.alu_b_sel      = ALU_B_SEL_MEM;
            bundle.alu_opcode     = ALU_MOV;
            bundle.update_regfile = 1'b1;
          end
          MEM_STOR: begin
            bundle.inst_type = TYPE_STORE;
            bundle.reg_a     = f_mid;
            bundle.reg_b     = f_lo;
          end
          MEM_JCOND: begin
            bundle.cond        = f_mid;
            bundle.reg_b       = f_lo;
            bundle.pc_disp_abs = 1'b1;
          end
          MEM_SCOND: begin
            bundle.inst_type      = TYPE_SCOND;
            bundle.reg_dst        = f_mid;
            bundle.cond           = f_lo;
            bundle.update_regfile = 1'b1;
          end
          default: bundle.illegal = 1'b1;
        endcase
      end
      OP_SHIFT: begin
        if (f_mid == 4'b0000 || f_mid == 4'b0001) begin
          bundle.reg_dst        = f_hi;
          bundle.reg_a          = f_hi;
          bundle.inst_imm       = {4'b0000, f_lo};
          bundle.alu_b_sel      = ALU_B_SEL_IMM;
          bundle.alu_opcode     = (f_mid[0]) ? ALU_ASH : ALU_LSH;
          bundle.update_regfile = 1'b1;
        end else begin
          bundle.illegal = 1'b1;
        end
      end
      OP_BCOND: begin
        bundle.cond             = f_hi;
        bundle.inst_imm         = inst[7:0];
        bundle.alu_b_imm_extend = 1'b1;
      end
      OP_MOVLI, OP_MOVUI: begin
        bundle.reg_dst        = f_hi;
        bundle.reg_a          = 4'd0;
        bundle.inst_imm       = inst[7:0];
        bundle.alu_b_sel      = (op == OP_MOVUI) ? ALU_B_SEL_IMM_HI : ALU_B_SEL_IMM;
        bundle.alu_opcode     = ALU_ADD;
        bundle.update_regfile = 1'b1;
      end
      default: begin
        if (alu_ok) begin
          bundle.reg_dst          = f_hi;
          bundle.reg_a            = f_hi;
          bundle.inst_imm         = inst[7:0];
          bundle.alu_b_sel        = ALU_B_SEL_IMM;
          bundle.alu_b_imm_extend = alu_arith;
          bundle.alu_opcode       = alu_op;
          bundle.update_flags     = alu_arith;
          bundle.update_regfile   = (alu_op != ALU_CMP);
        end else begin
          bundle.illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes each accepted instruction and queues the bundle with its PC in a
// DEPTH-entry FIFO between fetch and execute; flush empties the queue.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int PC_W   = 16,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [7:0]        inst_imm,
  output logic [3:0]        reg_a,
  output logic [3:0]        reg_b,
  output logic [3:0]        reg_dst,
  output logic [3:0]        cond,
  output logic [1:0]        inst_type,
  output logic              pc_disp_abs,
  output logic              alu_b_imm_extend,
  output logic [1:0]        alu_b_sel,
  output logic [3:0]        alu_opcode,
  output logic              update_flags,
  output logic              update_regfile,
  output logic              illegal
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  if (INST_W != ISA_INST_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("decode_stage: INST_W must be 16 and DEPTH a power of two >= 2");
  end

  typedef struct packed {
    logic [PC_W-1:0] pc;
    decode_bundle_t  fields;
  } entry_t;

  entry_t         slot_mem [DEPTH];
  entry_t         in_entry, head_entry;
  decode_bundle_t in_bundle, view_bundle;
  logic [AW-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic           push, pop;

  decode_logic u_decode (
    .inst   (in_inst),
    .bundle (in_bundle)
  );

  assign in_entry  = '{pc: in_pc, fields: in_bundle};
  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else if (flush) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage carries no reset; stale slots are hidden by the out_valid mask below.
  always_ff @(posedge clk) begin
    if (push) slot_mem[tail_reg] <= in_entry;
  end

  assign head_entry = slot_mem[head_reg];

  always_comb begin
    view_bundle = nop_bundle();
    out_pc      = '0;
    if (out_valid) begin
      view_bundle = head_entry.fields;
      out_pc      = head_entry.pc;
    end
  end

  assign inst_imm         = view_bundle.inst_imm;
  assign reg_a            = view_bundle.reg_a;
  assign reg_b            = view_bundle.reg_b;
  assign reg_dst          = view_bundle.reg_dst;
  assign cond             = view_bundle.cond;
  assign inst_type        = view_bundle.inst_type;
  assign pc_disp_abs      = view_bundle.pc_disp_abs;
  assign alu_b_imm_extend = view_bundle.alu_b_imm_extend;
  assign alu_b_sel        = view_bundle.alu_b_sel;
  assign alu_opcode       = view_bundle.alu_opcode;
  assign update_flags     = view_bundle.update_flags;
  assign update_regfile   = view_bundle.update_regfile;
  assign illegal          = view_bundle.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: mnemonic-level reference model plus directed vectors.
module tb_decode_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_inst, in_pc, out_pc;
  logic [7:0]  inst_imm;
  logic [3:0]  reg_a, reg_b, reg_dst, cond, alu_opcode;
  logic [1:0]  inst_type, alu_b_sel;
  logic        pc_disp_abs, alu_b_imm_extend, update_flags, update_regfile, illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .PC_W(16), .INST_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .inst_imm(inst_imm), .reg_a(reg_a),
    .reg_b(reg_b), .reg_dst(reg_dst), .cond(cond), .inst_type(inst_type),
    .pc_disp_abs(pc_disp_abs), .alu_b_imm_extend(alu_b_imm_extend),
    .alu_b_sel(alu_b_sel), .alu_opcode(alu_opcode), .update_flags(update_flags),
    .update_regfile(update_regfile), .illegal(illegal)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  imm;
    logic [3:0]  ra, rb, rd, cnd;
    logic [1:0]  typ;
    logic        abs_pc, ext;
    logic [1:0]  bsel;
    logic [3:0]  op;
    logic        uf, ur, ill;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string alu_name(logic [3:0] n);
    case (n)
      4'h1: return "AND";
      4'h2: return "OR";
      4'h3: return "XOR";
      4'h5: return "ADD";
      4'h7: return "ADDC";
      4'h9: return "SUB";
      4'hB: return "CMP";
      4'hD: return "MOV";
      default: return "";
    endcase
  endfunction

  function automatic logic [3:0] alu_num(string s);
    if (s == "ADD")  return 4'd0;
    if (s == "ADDC") return 4'd1;
    if (s == "SUB")  return 4'd2;
    if (s == "CMP")  return 4'd3;
    if (s == "AND")  return 4'd4;
    if (s == "OR")   return 4'd5;
    if (s == "XOR")  return 4'd6;
    return 4'd7;
  endfunction

  function automatic bit is_arith(string s);
    return s == "ADD" || s == "ADDC" || s == "SUB" || s == "CMP";
  endfunction

  // Reference decode by mnemonic: fields are filled from the ISA's operand layout.
  function automatic exp_t model_decode(logic [15:0] i, logic [15:0] pc);
    exp_t e;
    string nm;
    logic [3:0] a, b, c, d;
    a = i[15:12]; b = i[11:8]; c = i[7:4]; d = i[3:0];
    e = '0; e.pc = pc; e.cnd = 4'hF;
    if (i == 16'h0000) return e;
    case (a)
      4'h0: begin
        nm = alu_name(c);
        if (nm == "") e.ill = 1'b1;
        else begin
          e.rd = b; e.ra = b; e.rb = d; e.op = alu_num(nm);
          e.uf = is_arith(nm); e.ur = (nm != "CMP");
        end
      end
      4'h4: begin
        if (b == 4'h0) begin e.typ = 2'd1; e.rd = c; e.rb = d; e.bsel = 2'd3; e.op = 4'd7; e.ur = 1'b1; end
        else if (b == 4'h4) begin e.typ = 2'd2; e.ra = c; e.rb = d; end
        else if (b == 4'hC) begin e.cnd = c; e.rb = d; e.abs_pc = 1'b1; end
        else if (b == 4'hD) begin e.typ = 2'd3; e.rd = c; e.cnd = d; e.ur = 1'b1; end
        else e.ill = 1'b1;
      end
      4'h8: begin
        if (c <= 4'h1) begin
          e.rd = b; e.ra = b; e.imm = {4'h0, d}; e.bsel = 2'd1;
          e.op = (c == 4'h1) ? 4'd9 : 4'd8; e.ur = 1'b1;
        end else e.ill = 1'b1;
      end
      4'hC: begin e.cnd = b; e.imm = i[7:0]; e.ext = 1'b1; end
      4'hD, 4'hF: begin
        e.rd = b; e.imm = i[7:0]; e.bsel = (a == 4'hF) ? 2'd2 : 2'd1; e.ur = 1'b1;
      end
      default: begin
        nm = alu_name(a);
        if (nm == "") e.ill = 1'b1;
        else begin
          e.rd = b; e.ra = b; e.imm = i[7:0]; e.bsel = 2'd1; e.ext = is_arith(nm);
          e.op = alu_num(nm); e.uf = is_arith(nm); e.ur = (nm != "CMP");
        end
      end
    endcase
    return e;
  endfunction

  // Queue model of the FIFO.
  exp_t q[$];
  bit   m_push, m_pop;
  exp_t m_new;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        m_new = model_decode(in_inst, in_pc);
        q.push_back(m_new);
      end
    end
  end

  exp_t act;
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      act = '{pc: out_pc, imm: inst_imm, ra: reg_a, rb: reg_b, rd: reg_dst, cnd: cond,
              typ: inst_type, abs_pc: pc_disp_abs, ext: alu_b_imm_extend, bsel: alu_b_sel,
              op: alu_opcode, uf: update_flags, ur: update_regfile, ill: illegal};
      chk("head_bundle", 64'(act), 64'(q[0]));
    end else begin
      chk("illegal_masked", 64'(illegal), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc);
    in_valid = v; in_inst = inst; in_pc = pc;
  endtask

  logic [15:0] sweep [28] = '{
    16'h0152, 16'h0B7C, 16'h0391, 16'h04B2, 16'h0512, 16'h0623, 16'h0734, 16'h08D9,
    16'h06A1, 16'h1A0F, 16'h2BF0, 16'h3C33, 16'h75FF, 16'h9180, 16'hB47F, 16'h4012,
    16'h4434, 16'h4C57, 16'h4A00, 16'h8305, 16'h8417, 16'h8527, 16'hC7FE, 16'hD1FF,
    16'h6123, 16'hE000, 16'h0000, 16'hA555};

  initial begin
    int idx, budget;
    bit acc;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000);
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cond", 64'(cond), 64'hF);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_imm", 64'(inst_imm), 64'd0);
    reset_n = 1'b1;
    step();

    // ADDI r3, 5
    drive(1'b1, 16'h5305, 16'h0100);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_dst", 64'(reg_dst), 64'd3);
    chk("addi_imm", 64'(inst_imm), 64'h05);
    chk("addi_bsel", 64'(alu_b_sel), 64'd1);
    chk("addi_ext", 64'(alu_b_imm_extend), 64'd1);
    chk("addi_flags", 64'(update_flags), 64'd1);
    chk("addi_pc", 64'(out_pc), 64'h0100);
    out_ready = 1'b1;
    step();

    // Back-to-back MOVUI, Scond, illegal with out_ready high.
    drive(1'b1, 16'hF2AB, 16'h0200); step();
    chk("movui_bsel", 64'(alu_b_sel), 64'd2);
    chk("movui_rega", 64'(reg_a), 64'd0);
    chk("movui_dst", 64'(reg_dst), 64'd2);
    drive(1'b1, 16'h4D03, 16'h0202); step();
    chk("scond_type", 64'(inst_type), 64'd3);
    chk("scond_cond", 64'(cond), 64'd3);
    chk("scond_pc", 64'(out_pc), 64'h0202);
    drive(1'b1, 16'h0006, 16'h0204); step();
    chk("bad_illegal", 64'(illegal), 64'd1);
    chk("bad_regfile", 64'(update_regfile), 64'd0);
    chk("bad_cond", 64'(cond), 64'hF);
    drive(1'b0, 16'h0000, 16'h0000); step();

    // Fill with out_ready low, then full-hold with pop.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'h0152 + 16'(i), 16'h0300 + 16'(2 * i));
      step();
      chk("fill_in_ready", 64'(in_ready), 64'(i + 1 < DEPTH));
    end
    drive(1'b1, 16'hD1FF, 16'h03F0);
    out_ready = 1'b1;
    step();
    chk("full_pop_pc", 64'(out_pc), 64'h0302);
    chk("full_ready_after", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 16'h0000, 16'h0000);
    chk("late_push_pc", 64'(out_pc), 64'h03F0);
    step();
    chk("drained", 64'(out_valid), 64'd0);

    // Flush with a simultaneous push.
    out_ready = 1'b0;
    drive(1'b1, 16'h1A0F, 16'h0400); step();
    drive(1'b1, 16'h2BF0, 16'h0402); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 16'h0000, 16'h0000);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-stream with two entries queued.
    out_ready = 1'b0;
    drive(1'b1, 16'h4012, 16'h0500); step();
    drive(1'b1, 16'h4434, 16'h0502); step();
    drive(1'b0, 16'h0000, 16'h0000);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_ready", 64'(in_ready), 64'd1);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Sweep of encodings with out_ready stalling every third cycle.
    idx = 0; budget = 0;
    while (idx < 28 && budget < 200) begin
      drive(1'b1, sweep[idx], 16'h1000 + 16'(2 * idx));
      out_ready = (budget % 3) != 0;
      acc = in_ready;
      step();
      if (acc) idx++;
      budget++;
    end
    chk("sweep_done", 64'(idx), 64'd28);
    drive(1'b0, 16'h0000, 16'h0000);
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("sweep_drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
